// File: rtl/dispense_pkg.sv
// rtl/dispense_pkg.sv - shared types and constants for the dispense motor arbiter
package dispense_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    HALT = 2'd3
  } state_e;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_RUN_CYCLES = 8;
  localparam int DEF_GAP_CYCLES = 2;

  // One shared down-counter serves both the run and the cool-down phases.
  function automatic int CNT_W(input int run_cycles, input int gap_cycles);
    int m;
    m = (run_cycles > gap_cycles) ? run_cycles : gap_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or above the pointer, wrapping
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_valid
);

  logic [N_REQ-1:0] w_hi;

  always_comb begin
    w_hi = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_hi[i] = i_req[i] & (PTR_W'(i) >= i_ptr);
    end
  end

  // Lowest request overall is the wrap-around fallback; any request at/above the pointer wins over it.
  always_comb begin
    o_grant = '0;
    o_valid = |i_req;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_hi[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dispense_arbiter.sv
// rtl/dispense_arbiter.sv - round-robin owner of the single dispense motor with fixed run and cool-down
module dispense_arbiter
  import dispense_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int RUN_CYCLES = DEF_RUN_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             stop,
  output logic [N_REQ-1:0] grant,
  output logic             motor,
  output logic [N_REQ-1:0] done,
  output logic             abort,
  output logic             busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW    = CNT_W(RUN_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] RUN_LOAD = CW'(RUN_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt, w_ptr_adv;
  logic [N_REQ-1:0] r_grant, r_done;
  logic             r_motor, r_abort, r_busy;

  logic [N_REQ-1:0] w_pick;
  logic             w_valid;
  logic             w_withdraw;
  logic [N_REQ-1:0] w_grant_nxt, w_done_nxt;
  logic             w_motor_nxt, w_abort_nxt, w_busy_nxt;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick),
    .o_valid (w_valid)
  );

  always_comb begin
    w_ptr_adv = '0;
    for (int i = 0; i < N_REQ - 1; i++) begin
      if (w_pick[i]) w_ptr_adv = PTR_W'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
      r_motor <= 1'b0;
      r_done  <= '0;
      r_abort <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_motor <= w_motor_nxt;
      r_done  <= w_done_nxt;
      r_abort <= w_abort_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // RUN exit priority: stop, then withdrawal of the owner's request, then run completion.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_withdraw  = 1'b0;
    case (r_state)
      IDLE: begin
        if (stop) begin
          w_state_nxt = HALT;
        end else if (w_valid) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = RUN_LOAD;
          w_ptr_nxt   = w_ptr_adv;
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = HALT;
        end else if ((req & r_grant) == '0) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = GAP_LOAD;
          w_withdraw  = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      GAP: begin
        if (stop) begin
          w_state_nxt = HALT;
        end else if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      HALT: begin
        if (!stop) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = GAP_LOAD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // done is raised one edge early so it lands in the last motor cycle of the run.
  always_comb begin
    w_grant_nxt = '0;
    w_motor_nxt = 1'b0;
    w_done_nxt  = '0;
    w_abort_nxt = w_withdraw;
    w_busy_nxt  = (w_state_nxt != IDLE);
    if (w_state_nxt == RUN) begin
      w_motor_nxt = 1'b1;
      w_grant_nxt = (r_state == IDLE) ? w_pick : r_grant;
      if (w_cnt_nxt == '0) w_done_nxt = w_grant_nxt;
    end
  end

  assign grant = r_grant;
  assign motor = r_motor;
  assign done  = r_done;
  assign abort = r_abort;
  assign busy  = r_busy;

endmodule

// File: tb/tb_dispense_arbiter.sv
// tb/tb_dispense_arbiter.sv - directed self-checking bench for dispense_arbiter
module tb_dispense_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       stop = 1'b0;
  logic [3:0] grant, done;
  logic       motor, abort, busy;

  int errors = 0;
  int checks = 0;

  dispense_arbiter #(.N_REQ(4), .RUN_CYCLES(8), .GAP_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .stop  (stop),
    .grant (grant),
    .motor (motor),
    .done  (done),
    .abort (abort),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // After tick() returns, outputs show the cycle that follows that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle: busy=%b expected 0", name, busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    tick(); tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (motor !== 1'b0) begin errors++; $display("FAIL reset_motor: got %b expected 0", motor); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", abort); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    req   = 4'b0000;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    req = 4'b1111;
    for (int k = 1; k <= 45; k++) begin
      tick();
      checks++;
      if (!$onehot0(grant)) begin errors++; $display("FAIL fair_onehot k=%0d: grant=%b", k, grant); end
      checks++;
      if (done !== 4'b0000 && abort !== 1'b0) begin errors++; $display("FAIL fair_done_abort k=%0d: done=%b abort=%b", k, done, abort); end
      exp = 4'bxxxx;
      case (k)
        1:  exp = 4'b0001;
        12: exp = 4'b0010;
        23: exp = 4'b0100;
        34: exp = 4'b1000;
        45: exp = 4'b0001;
        11: exp = 4'b0000;
        default: ;
      endcase
      if (k == 1 || k == 11 || k == 12 || k == 23 || k == 34 || k == 45) begin
        checks++;
        if (grant !== exp) begin errors++; $display("FAIL fair_grant k=%0d: got %b expected %b", k, grant, exp); end
      end
      if (k == 8) begin
        checks++;
        if (done !== 4'b0001) begin errors++; $display("FAIL fair_done k=8: got %b expected 0001", done); end
      end
    end
  endtask

  task automatic test_midrun_reset();
    tick(); tick(); tick(); tick();
    checks++; if (motor !== 1'b1) begin errors++; $display("FAIL mid_pre_motor: got %b expected 1", motor); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (motor !== 1'b0) begin errors++; $display("FAIL mid_motor: got %b expected 0", motor); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_grant: got %b expected 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mid_ptr_grant: got %b expected 0001", grant); end
    req = 4'b0000;
    wait_idle("mid");
  endtask

  task automatic test_single();
    req = 4'b0100;
    for (int k = 1; k <= 11; k++) begin
      tick();
      checks++;
      if (grant !== ((k <= 8) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_grant k=%0d: got %b", k, grant); end
      checks++;
      if (motor !== (k <= 8)) begin errors++; $display("FAIL single_motor k=%0d: got %b", k, motor); end
      checks++;
      if (done !== ((k == 8) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_done k=%0d: got %b", k, done); end
      checks++;
      if (busy !== (k <= 10)) begin errors++; $display("FAIL single_busy k=%0d: got %b", k, busy); end
      if (k == 9) req = 4'b0000;
    end
  endtask

  task automatic test_withdrawal();
    req = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (done !== 4'b0000) begin errors++; $display("FAIL wd_done k=%0d: got %b expected 0000", k, done); end
      case (k)
        1: begin checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL wd_grant: got %b expected 0010", grant); end end
        4: begin
          checks++; if (motor !== 1'b1) begin errors++; $display("FAIL wd_motor4: got %b expected 1", motor); end
          req = 4'b0000;
        end
        5: begin
          checks++; if (motor !== 1'b0) begin errors++; $display("FAIL wd_motor5: got %b expected 0", motor); end
          checks++; if (abort !== 1'b1) begin errors++; $display("FAIL wd_abort5: got %b expected 1", abort); end
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wd_busy5: got %b expected 1", busy); end
        end
        6: begin
          checks++; if (abort !== 1'b0) begin errors++; $display("FAIL wd_abort6: got %b expected 0", abort); end
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wd_busy6: got %b expected 1", busy); end
        end
        7: begin
          checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_busy7: got %b expected 0", busy); end
          req = 4'b0110;
        end
        8: begin checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL wd_next_grant: got %b expected 0100", grant); end end
        default: ;
      endcase
    end
    req = 4'b0000;
    wait_idle("wd");
  endtask

  task automatic test_stop();
    req = 4'b1000;
    for (int k = 1; k <= 14; k++) begin
      tick();
      checks++;
      if (abort !== 1'b0 || done !== 4'b0000) begin errors++; $display("FAIL stop_pulse k=%0d: abort=%b done=%b expected 0", k, abort, done); end
      case (k)
        1: begin checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL stop_grant1: got %b expected 1000", grant); end end
        3: begin
          checks++; if (motor !== 1'b1) begin errors++; $display("FAIL stop_motor3: got %b expected 1", motor); end
          stop = 1'b1;
        end
        4: begin
          checks++; if (motor !== 1'b0) begin errors++; $display("FAIL stop_motor4: got %b expected 0", motor); end
          checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL stop_grant4: got %b expected 0000", grant); end
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stop_busy4: got %b expected 1", busy); end
        end
        10: begin
          checks++; if (busy !== 1'b1 || motor !== 1'b0) begin errors++; $display("FAIL stop_halt10: busy=%b motor=%b expected 1 0", busy, motor); end
          stop = 1'b0;
        end
        11, 12: begin checks++; if (busy !== 1'b1 || grant !== 4'b0000) begin errors++; $display("FAIL stop_gap k=%0d: busy=%b grant=%b expected 1 0000", k, busy, grant); end end
        13: begin checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_idle13: busy=%b expected 0", busy); end end
        14: begin
          checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL stop_regrant: got %b expected 1000", grant); end
          checks++; if (motor !== 1'b1) begin errors++; $display("FAIL stop_motor14: got %b expected 1", motor); end
        end
        default: ;
      endcase
    end
    req = 4'b0000;
    wait_idle("stop");
  endtask

  task automatic test_stop_idle();
    stop = 1'b1;
    tick();
    checks++; if (busy !== 1'b1 || motor !== 1'b0) begin errors++; $display("FAIL idle_halt: busy=%b motor=%b expected 1 0", busy, motor); end
    stop = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL idle_gap: busy=%b expected 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_back: busy=%b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_midrun_reset();
    test_single();
    test_withdrawal();
    test_stop();
    test_stop_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
